qsgmii_an_transmitter: RTL

QSGMII_AN_TRANSMITTER -- requirements
Module: qsgmii_an_transmitter

---
 rtl/qsgmii_an_transmitter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/qsgmii_an_transmitter.sv
// qsgmii_an_transmitter
//   Drives the 4-lane QSGMII TX word during clause-37 style autonegotiation.
//   Each port runs its own CONFIG -> ACK -> DATA sequence and sends /C1/,/C2/
//   config sets or /I2/ idles. All ports share one 2-bit phase counter, so
//   ordered sets stay aligned across lanes. Lane 0 carries K28.1 in place of
//   K28.5 as the QSGMII lane marker.
//
// Ports
//   tx_clk          SERDES TX word clock
//   rst             asynchronous active-high reset
//   port_link_up    per-port link state advertised in the config word
//   port_speed      per-port speed, port i in bits [2i+1:2i]
//   rx_cfg_ack      per-port level: partner is sending /C/ with ack set
//   restart_an      per-port single-cycle restart request
//   tx_data         encoder input, byte i is port i
//   tx_data_is_ctl  K flag per byte
//   an_done         per-port, high while the port is in DATA
//
// State | meaning
//   CONFIG | sending /C/ with ack=0, waiting for partner ack
//   ACK    | sending /C/ with ack=1, counting ACK_SETS sets
//   DATA   | negotiation complete, sending /I2/
module qsgmii_an_transmitter #(
  parameter int CONFIG_MIN_SETS = 8,
  parameter int ACK_SETS        = 16
) (
  input  logic        tx_clk,
  input  logic        rst,
  input  logic [3:0]  port_link_up,
  input  logic [7:0]  port_speed,
  input  logic [3:0]  rx_cfg_ack,
  input  logic [3:0]  restart_an,
  output logic [31:0] tx_data,
  output logic [3:0]  tx_data_is_ctl,
  output logic [3:0]  an_done
);

  typedef enum logic [1:0] {
    ST_CONFIG = 2'd0,
    ST_ACK    = 2'd1,
    ST_DATA   = 2'd2
  } an_state_t;

  localparam logic [4:0] MIN_C    = 5'(CONFIG_MIN_SETS);
  localparam logic [4:0] ACK_LAST = 5'(ACK_SETS - 1);
  localparam logic [4:0] CNT_MAX  = 5'd31;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;
  localparam logic [7:0] D16_2 = 8'h50;

  logic [1:0]  phase_q, phase_d;
  an_state_t   state_q [4];
  an_state_t   state_d [4];
  logic [4:0]  cnt_q [4];
  logic [4:0]  cnt_d [4];
  logic [15:0] cfg_q [4];
  logic [15:0] cfg_d [4];
  logic [3:0]  c2_q, c2_d;       // next/current set is /C2/
  logic [3:0]  pend_q, pend_d;   // restart seen since last boundary
  logic [3:0]  chg_q, chg_d;     // link/speed differed at a phase-0 relatch
  logic [3:0]  link_q, link_d;
  logic [7:0]  speed_q, speed_d;
  logic        valid_q, valid_d; // link/speed latches hold real data

  logic [31:0] tx_data_q, tx_data_d;
  logic [3:0]  ctl_q, ctl_d;
  logic [3:0]  done_q, done_d;

  assign phase_d = phase_q + 2'd1;

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      phase_q   <= 2'd0;
      c2_q      <= 4'd0;
      pend_q    <= 4'd0;
      chg_q     <= 4'd0;
      link_q    <= 4'd0;
      speed_q   <= 8'd0;
      valid_q   <= 1'b0;
      tx_data_q <= 32'hBCBC_BC3C;
      ctl_q     <= 4'hF;
      done_q    <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= ST_CONFIG;
        cnt_q[i]   <= 5'd0;
        cfg_q[i]   <= 16'd0;
      end
    end else begin
      phase_q   <= phase_d;
      c2_q      <= c2_d;
      pend_q    <= pend_d;
      chg_q     <= chg_d;
      link_q    <= link_d;
      speed_q   <= speed_d;
      valid_q   <= valid_d;
      tx_data_q <= tx_data_d;
      ctl_q     <= ctl_d;
      done_q    <= done_d;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        cfg_q[i]   <= cfg_d[i];
      end
    end
  end

  // Per-port next state. Inputs are relatched at phase 0; transitions are
  // only taken at phase 3 so a set is never cut short.
  always_comb begin
    logic [1:0] spd_in;
    logic       restart;
    logic       change;
    spd_in  = 2'd0;
    restart = 1'b0;
    change  = 1'b0;
    c2_d    = c2_q;
    pend_d  = pend_q | restart_an;
    chg_d   = chg_q;
    link_d  = link_q;
    speed_d = speed_q;
    valid_d = valid_q;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      cfg_d[i]   = cfg_q[i];
    end

    if (phase_q == 2'd0) begin
      valid_d = 1'b1;
    end

    for (int i = 0; i < 4; i++) begin
      spd_in = port_speed[2*i +: 2];
      if (phase_q == 2'd0) begin
        // A change landing exactly on phase 0 would be hidden by the relatch,
        // so remember it for the coming boundary.
        chg_d[i] = valid_q & ((port_link_up[i] != link_q[i]) |
                              (spd_in != speed_q[2*i +: 2]));
        link_d[i]           = port_link_up[i];
        speed_d[2*i +: 2]   = spd_in;
        cfg_d[i] = {port_link_up[i], (state_q[i] != ST_CONFIG), 1'b0, 1'b1,
                    spd_in, 9'd0, 1'b1};
      end
      if (phase_q == 2'd3) begin
        restart = pend_q[i] | restart_an[i];
        change  = chg_q[i] | (port_link_up[i] != link_q[i]) |
                  (spd_in != speed_q[2*i +: 2]);
        pend_d[i] = 1'b0;
        chg_d[i]  = 1'b0;
        if (restart || change) begin
          state_d[i] = ST_CONFIG;
          cnt_d[i]   = 5'd0;
          c2_d[i]    = 1'b0;
        end else if (state_q[i] == ST_CONFIG && cnt_q[i] >= MIN_C &&
                     rx_cfg_ack[i] && link_q[i]) begin
          state_d[i] = ST_ACK;
          cnt_d[i]   = 5'd0;
          c2_d[i]    = ~c2_q[i];
        end else if (state_q[i] == ST_ACK && cnt_q[i] == ACK_LAST) begin
          state_d[i] = ST_DATA;
          c2_d[i]    = ~c2_q[i];
        end else if (state_q[i] == ST_ACK && !rx_cfg_ack[i]) begin
          state_d[i] = ST_CONFIG;
          cnt_d[i]   = 5'd0;
          c2_d[i]    = 1'b0;
        end else begin
          cnt_d[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + 5'd1;
          c2_d[i]  = ~c2_q[i];
        end
      end
    end
  end

  // Symbol selection for the current phase; registered into the output.
  always_comb begin
    logic [7:0] b;
    logic       k;
    b         = 8'd0;
    k         = 1'b0;
    tx_data_d = 32'd0;
    ctl_d     = 4'd0;
    done_d    = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (state_q[i] == ST_DATA) begin
        k = ~phase_q[0];
        b = phase_q[0] ? D16_2 : K28_5;
      end else begin
        k = (phase_q == 2'd0);
        case (phase_q)
          2'd0:    b = K28_5;
          2'd1:    b = c2_q[i] ? D2_2 : D21_5;
          2'd2:    b = cfg_q[i][7:0];
          default: b = cfg_q[i][15:8];
        endcase
      end
      if (i == 0 && k && b == K28_5) begin
        b = K28_1;
      end
      tx_data_d[8*i +: 8] = b;
      ctl_d[i]            = k;
      done_d[i]           = (state_q[i] == ST_DATA);
    end
  end

  assign tx_data        = tx_data_q;
  assign tx_data_is_ctl = ctl_q;
  assign an_done        = done_q;

endmodule
